// File: rtl/seg_capture_decoder.sv
// -----------------------------------------------------------------------------
// seg_capture_decoder
//
// Samples an active-low 7-segment pattern, waits until the same valid pattern
// has been seen for STABLE_CYCLES consecutive samples, and decodes it back to
// the 3-bit excess-3 digit code ((d + 3) mod 8). Legal results leave through
// a one-entry valid/ready buffer. Illegal patterns pulse err and bump a
// saturating counter. A re-arm rule stops a static display from producing a
// stream of repeated results.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed before a decision (1..255)
//   ERR_CNT_W      width of the illegal-pattern counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   seg_in     segment pattern, active-low, [6]=g .. [0]=a
//   seg_valid  seg_in is meaningful this cycle
//   num_out    decoded excess-3 code
//   num_valid  num_out holds an undelivered result
//   num_ready  consumer accepts num_out
//   err        one-cycle pulse: a stable pattern was illegal
//   err_count  saturating count of illegal patterns
//   busy       high while settling or holding a result
// -----------------------------------------------------------------------------
module seg_capture_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_in,
    input  logic                 seg_valid,
    output logic [2:0]           num_out,
    output logic                 num_valid,
    input  logic                 num_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // cnt holds the number of matching samples seen so far; the decision is
    // taken on the edge where it would reach STABLE_CYCLES, so compare against
    // STABLE_CYCLES-1 to stay inside 8 bits for the full 1..255 range.
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [6:0] cap;
    logic [7:0] cnt;
    logic       armed;
    logic [6:0] last_pat;

    logic       capture, count, decide, deliver;
    logic [6:0] dec_pat;
    logic       dec_legal;
    logic [2:0] dec_code;
    logic       eligible;

    // Returns {legal, code}.
    function automatic logic [3:0] decode(input logic [6:0] pat);
        case (pat)
            7'b1000000: return 4'b1_011;  // 0
            7'b1111001: return 4'b1_100;  // 1
            7'b0100100: return 4'b1_101;  // 2
            7'b0110000: return 4'b1_110;  // 3
            7'b0011001: return 4'b1_111;  // 4
            7'b0010010: return 4'b1_000;  // 5
            7'b0000010: return 4'b1_001;  // 6
            7'b1111000: return 4'b1_010;  // 7
            default:    return 4'b0_000;
        endcase
    endfunction

    // A sample differing from the last decided pattern arms the block on the
    // same cycle, so it must also be eligible for capture right away.
    assign eligible = seg_valid && (armed || (seg_in != last_pat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt = state;
        capture   = 1'b0;
        count     = 1'b0;
        decide    = 1'b0;
        deliver   = 1'b0;
        dec_pat   = cap;

        case (state)
            IDLE: begin
                if (eligible) begin
                    capture = 1'b1;
                    if (STABLE_CYCLES == 1) begin
                        decide  = 1'b1;
                        dec_pat = seg_in;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!seg_valid) begin
                    state_nxt = IDLE;
                end else if (seg_in == cap) begin
                    if (cnt == LAST_CNT) decide = 1'b1;
                    else                 count  = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (num_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        {dec_legal, dec_code} = decode(dec_pat);
        if (decide) state_nxt = dec_legal ? HOLD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap       <= 7'b0;
            cnt       <= 8'd0;
            armed     <= 1'b1;
            last_pat  <= 7'b1111111;
            num_out   <= 3'b000;
            num_valid <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values and later statements may override
            // earlier ones (decide clearing armed wins over re-arming).
            err <= 1'b0;

            if (!seg_valid || (seg_in != last_pat)) armed <= 1'b1;

            if (capture) begin
                cap <= seg_in;
                cnt <= 8'd1;
            end else if (count) begin
                cnt <= cnt + 8'd1;
            end

            if (decide) begin
                last_pat <= dec_pat;
                armed    <= 1'b0;
                if (dec_legal) begin
                    num_out   <= dec_code;
                    num_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                    if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                end
            end

            if (deliver) num_valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg_capture_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_capture_decoder
//
// Bench for seg_capture_decoder. Two instances share the stimulus: dut_a uses
// the default parameters, dut_b uses a 2-bit error counter to exercise
// saturation. Expected digit codes are pushed to a queue when a stable legal
// pattern is driven and popped when dut_a completes a valid/ready transfer.
// -----------------------------------------------------------------------------
module tb_seg_capture_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       num_ready;

    logic [2:0] num_out_a, num_out_b;
    logic       num_valid_a, num_valid_b;
    logic       err_a, err_b;
    logic [7:0] err_count_a;
    logic [1:0] err_count_b;
    logic       busy_a, busy_b;

    seg_capture_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid),
        .num_out(num_out_a), .num_valid(num_valid_a), .num_ready(num_ready),
        .err(err_a), .err_count(err_count_a), .busy(busy_a)
    );

    seg_capture_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid),
        .num_out(num_out_b), .num_valid(num_valid_b), .num_ready(num_ready),
        .err(err_b), .err_count(err_count_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         err_seen_a   = 0;
    int         err_seen_b   = 0;
    int         exp_pulses   = 0;  // err pulses expected since time zero
    int         exp_cnt      = 0;  // illegal patterns expected since last reset
    logic [2:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and return just after the sampling edge.
    task automatic step(input logic [6:0] pat, input logic v, input logic r);
        seg_in    = pat;
        seg_valid = v;
        num_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_err_counts(input string tag);
        check({tag, "_cnt_a"}, 32'(err_count_a), 32'(exp_cnt));
        check({tag, "_cnt_b"}, 32'(err_count_b), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
        check({tag, "_pulses_a"}, 32'(err_seen_a), 32'(exp_pulses));
        check({tag, "_pulses_b"}, 32'(err_seen_b), 32'(exp_pulses));
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_a) err_seen_a++;
            if (err_b) err_seen_b++;
            if (err_a && num_valid_a) check("err_with_valid", 32'(num_valid_a), 32'd0);
            if (num_valid_a && num_ready) begin
                if (sb_q.size() == 0) check("sb_unexpected", 32'(sb_q.size()), 32'd1);
                else                  check("sb_result", 32'(num_out_a), 32'(sb_q.pop_front()));
            end
        end
    end

    localparam logic [6:0] ILLEGAL[5] = '{7'h7F, 7'h00, 7'h55, 7'h2A, 7'h11};

    initial begin
        rst       = 1'b1;
        seg_in    = 7'h7F;
        seg_valid = 1'b0;
        num_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state.
        check("rst_num_out",   32'(num_out_a),   32'd0);
        check("rst_num_valid", 32'(num_valid_a), 32'd0);
        check("rst_err",       32'(err_a),       32'd0);
        check("rst_err_count", 32'(err_count_a), 32'd0);
        check("rst_busy",      32'(busy_a),      32'd0);

        // Digit 2 held for 6 cycles: one result after the 4th sample edge only.
        sb_q.push_back(3'b101);
        for (int k = 1; k <= 6; k++) begin
            step(7'b0100100, 1'b1, 1'b1);
            check($sformatf("t1_valid_%0d", k), 32'(num_valid_a), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("t1_num_out", 32'(num_out_a), 32'b101);
        end
        check("t1_busy_after", 32'(busy_a), 32'd0);
        step(7'h7F, 1'b0, 1'b1);

        // 4 held twice then 6 held four times: recapture, single result 001.
        sb_q.push_back(3'b001);
        repeat (2) step(7'b0011001, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(7'b0000010, 1'b1, 1'b1);
            check($sformatf("t2_valid_%0d", k), 32'(num_valid_a), (k == 4) ? 32'd1 : 32'd0);
        end
        check("t2_num_out", 32'(num_out_a), 32'b001);
        step(7'h7F, 1'b0, 1'b1);
        check_err_counts("t2");

        // Illegal all-off held twice, separated by a seg_valid=0 gap.
        repeat (4) step(7'b1111111, 1'b1, 1'b1);
        check("t3_err_first", 32'(err_a), 32'd1);
        step(7'b1111111, 1'b0, 1'b1);
        check("t3_err_gap", 32'(err_a), 32'd0);
        repeat (4) step(7'b1111111, 1'b1, 1'b1);
        check("t3_err_second", 32'(err_a), 32'd1);
        exp_pulses += 2;
        exp_cnt    += 2;
        step(7'h7F, 1'b0, 1'b1);
        check_err_counts("t3");

        // Result 110 held back by num_ready=0 while seg_in keeps changing.
        sb_q.push_back(3'b110);
        repeat (4) step(7'b0110000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(7'($urandom_range(0, 127)), 1'b1, 1'b0);
            check($sformatf("t4_hold_out_%0d", k),   32'(num_out_a),   32'b110);
            check($sformatf("t4_hold_valid_%0d", k), 32'(num_valid_a), 32'd1);
        end
        step(7'($urandom_range(0, 127)), 1'b1, 1'b1);
        check("t4_delivered", 32'(num_valid_a), 32'd0);
        check("t4_idle",      32'(busy_a),      32'd0);
        step(7'h7F, 1'b0, 1'b1);

        // Five illegal stable patterns with gaps: dut_b saturates at 3.
        for (int p = 0; p < 5; p++) begin
            repeat (4) step(ILLEGAL[p], 1'b1, 1'b1);
            step(ILLEGAL[p], 1'b0, 1'b1);
            exp_pulses++;
            exp_cnt++;
        end
        check_err_counts("t5");

        // Asynchronous reset mid-SETTLE.
        repeat (2) step(7'b1000000, 1'b1, 1'b1);
        check("t6_settle_busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst1_busy",  32'(busy_a),      32'd0);
        check("t6_rst1_cnt_a", 32'(err_count_a), 32'd0);
        check("t6_rst1_cnt_b", 32'(err_count_b), 32'd0);
        seg_valid = 1'b0;
        exp_cnt   = 0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in HOLD discards the pending result.
        repeat (4) step(7'b1000000, 1'b1, 1'b0);
        check("t6_hold_valid", 32'(num_valid_a), 32'd1);
        check("t6_hold_out",   32'(num_out_a),   32'b011);
        #2 rst = 1'b1;
        #1;
        check("t6_rst2_valid", 32'(num_valid_a), 32'd0);
        check("t6_rst2_out",   32'(num_out_a),   32'd0);
        check("t6_rst2_busy",  32'(busy_a),      32'd0);
        check("t6_rst2_err",   32'(err_a),       32'd0);
        seg_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // After release the same pattern is accepted again.
        sb_q.push_back(3'b011);
        repeat (4) step(7'b1000000, 1'b1, 1'b1);
        check("t6_post_valid", 32'(num_valid_a), 32'd1);
        check("t6_post_out",   32'(num_out_a),   32'b011);
        step(7'b1000000, 1'b1, 1'b1);
        step(7'h7F, 1'b0, 1'b1);
        check_err_counts("t6");

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
